// File: rtl/equality_bist.sv
// equality_bist: built-in self-test engine for an equality detector.
// Sweeps every (A, B) pair of WIDTH-bit operands into the detector under
// test. Each vector is held for SETTLE cycles and then the detector's result
// is compared with A == B. The engine reports the error count, pass/fail and
// the first failing vector.
//
// Ports:
//   clk        - clock; all state updates on the rising edge
//   rst        - synchronous reset, active-high (takes priority over start)
//   start      - level; starts a sweep when sampled in IDLE or DONE
//   eq_in      - detector result (1 = operands equal)
//   a_out      - operand A to detector (outer loop), 0 when not sweeping
//   b_out      - operand B to detector (inner loop), 0 when not sweeping
//   busy       - high while a sweep is running
//   done       - high from sweep completion until next start or reset
//   pass       - valid while done; 1 when no mismatches were seen
//   err_count  - number of mismatching vectors (max 2^(2*WIDTH))
//   fail_valid - high once a mismatch has been recorded
//   fail_a     - A operand of the first mismatch
//   fail_b     - B operand of the first mismatch
module equality_bist #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               eq_in,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               fail_valid,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b
);

  localparam int unsigned VW = 2 * WIDTH;
  localparam int unsigned CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [VW-1:0]    vec_q,  vec_d;
  logic [CW-1:0]    cnt_q,  cnt_d;
  logic [VW:0]      err_q,  err_d;
  logic             fv_q,   fv_d;
  logic [WIDTH-1:0] fa_q,   fa_d;
  logic [WIDTH-1:0] fb_q,   fb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic [WIDTH-1:0] cur_a;
  logic [WIDTH-1:0] cur_b;
  logic             last_vec;
  logic             settled;
  logic             mismatch;

  assign cur_a    = vec_q[VW-1:WIDTH];
  assign cur_b    = vec_q[WIDTH-1:0];
  assign last_vec = (vec_q == '1);
  assign settled  = (cnt_q == CW'(SETTLE));
  assign mismatch = (eq_in != (cur_a == cur_b));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start)    state_d = S_WAIT;
      S_WAIT:         if (settled)  state_d = S_CHECK;
      S_CHECK:        state_d = last_vec ? S_DONE : S_WAIT;
      default:        state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    vec_d  = vec_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    fv_d   = fv_q;
    fa_d   = fa_q;
    fb_d   = fb_q;
    busy_d = busy_q;
    done_d = done_q;
    pass_d = pass_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_d  = '0;
          cnt_d  = CW'(1);
          err_d  = '0;
          fv_d   = 1'b0;
          fa_d   = '0;
          fb_d   = '0;
          busy_d = 1'b1;
          done_d = 1'b0;
          pass_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (!settled) cnt_d = cnt_q + CW'(1);
      end
      S_CHECK: begin
        if (mismatch) begin
          err_d = err_q + (VW+1)'(1);
          if (!fv_q) begin
            fv_d = 1'b1;
            fa_d = cur_a;
            fb_d = cur_b;
          end
        end
        // The counter wraps from all-ones to zero on the last vector, which
        // leaves the operand outputs at 0 in DONE without extra muxing.
        vec_d = vec_q + VW'(1);
        cnt_d = CW'(1);
        if (last_vec) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (err_d == '0);
        end
      end
      default: ;
    endcase
  end

  // Datapath / output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q  <= '0;
      cnt_q  <= CW'(1);
      err_q  <= '0;
      fv_q   <= 1'b0;
      fa_q   <= '0;
      fb_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      vec_q  <= vec_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      fv_q   <= fv_d;
      fa_q   <= fa_d;
      fb_q   <= fb_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
    end
  end

  assign a_out      = cur_a;
  assign b_out      = cur_b;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fv_q;
  assign fail_a     = fa_q;
  assign fail_b     = fb_q;

endmodule

// File: tb/tb_equality_bist.sv
// Self-checking bench for equality_bist: one instance with WIDTH=1/SETTLE=1
// driven by a configurable detector model, one with WIDTH=2/SETTLE=2 driven
// by a golden detector.
module tb_equality_bist;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start1, start2;

  // WIDTH=1, SETTLE=1 instance
  logic       eq1;
  logic [0:0] a1, b1, fa1, fb1;
  logic       busy1, done1, pass1, fv1;
  logic [2:0] err1;
  int         mode1;  // 0 golden, 1 stuck-0, 2 stuck-1, 3 inverted

  // WIDTH=2, SETTLE=2 instance
  logic       eq2;
  logic [1:0] a2, b2, fa2, fb2;
  logic       busy2, done2, pass2, fv2;
  logic [4:0] err2;

  equality_bist #(.WIDTH(1), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .eq_in(eq1),
    .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1)
  );

  equality_bist #(.WIDTH(2), .SETTLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .eq_in(eq2),
    .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_valid(fv2), .fail_a(fa2), .fail_b(fb2)
  );

  always_comb begin
    eq1 = (a1 == b1);
    case (mode1)
      1:       eq1 = 1'b0;
      2:       eq1 = 1'b1;
      3:       eq1 = (a1 != b1);
      default: eq1 = (a1 == b1);
    endcase
  end

  assign eq2 = (a2 == b2);

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard of operand pairs expected on the detector interface
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
  } op_t;
  op_t sb[$];

  task automatic pop_cmp(input string name, input logic [7:0] a, input logic [7:0] b);
    op_t op;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      op = sb.pop_front();
      chk({name, "_a"}, a, op.a);
      chk({name, "_b"}, b, op.b);
    end
  endtask

  // Expected sweep outcome per detector mode (WIDTH=1, SETTLE=1)
  typedef struct {
    string name;
    int    mode;
    int    exp_err;
    bit    exp_pass;
    bit    exp_fv;
    bit    exp_fa;
    bit    exp_fb;
    int    poke;  // edge at which start is re-asserted mid-sweep, -1 none
  } vec_t;

  // Runs a full sweep on u_dut1. Start is captured at E0; afterwards the
  // bench sits #1 after each edge E_e when it samples.
  task automatic sweep1(input vec_t v);
    mode1 = v.mode;
    for (int k = 0; k < 4; k++) sb.push_back('{a: 8'(k >> 1), b: 8'(k & 1)});
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    for (int e = 0; e < 8; e++) begin
      chk({v.name, "_busy"}, busy1, 1);
      chk({v.name, "_done_low"}, done1, 0);
      if (e == 0) begin
        chk({v.name, "_err_clr"}, err1, 0);
        chk({v.name, "_fv_clr"}, fv1, 0);
      end
      if (e % 2 == 0) pop_cmp({v.name, "_op"}, 8'(a1), 8'(b1));
      start1 = (e + 1 == v.poke);
      @(posedge clk); #1;
    end
    start1 = 1'b0;
    chk({v.name, "_done"}, done1, 1);
    chk({v.name, "_busy_end"}, busy1, 0);
    chk({v.name, "_pass"}, pass1, v.exp_pass);
    chk({v.name, "_err"}, err1, v.exp_err);
    chk({v.name, "_fv"}, fv1, v.exp_fv);
    chk({v.name, "_fa"}, fa1, v.exp_fa);
    chk({v.name, "_fb"}, fb1, v.exp_fb);
    chk({v.name, "_a_idle"}, {a1, b1}, 0);
    chk({v.name, "_sb_drained"}, sb.size(), 0);
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{name: "stuck0",   mode: 1, exp_err: 2, exp_pass: 0, exp_fv: 1, exp_fa: 0, exp_fb: 0, poke: -1};
    tbl[1] = '{name: "stuck1",   mode: 2, exp_err: 2, exp_pass: 0, exp_fv: 1, exp_fa: 0, exp_fb: 1, poke: -1};
    tbl[2] = '{name: "inverted", mode: 3, exp_err: 4, exp_pass: 0, exp_fv: 1, exp_fa: 0, exp_fb: 0, poke: -1};
    tbl[3] = '{name: "golden",   mode: 0, exp_err: 0, exp_pass: 1, exp_fv: 0, exp_fa: 0, exp_fb: 0, poke: -1};
    tbl[4] = '{name: "restart_ignored", mode: 0, exp_err: 0, exp_pass: 1, exp_fv: 0, exp_fa: 0, exp_fb: 0, poke: 3};

    rst = 1'b1; start1 = 1'b0; start2 = 1'b0; mode1 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    chk("rst_busy1", busy1, 0);
    chk("rst_done1", done1, 0);
    chk("rst_pass1", pass1, 0);
    chk("rst_err1", err1, 0);
    chk("rst_fv1", fv1, 0);
    chk("rst_ops1", {a1, b1, fa1, fb1}, 0);
    chk("rst_state2", {busy2, done2, pass2, fv2, err2, a2, b2, fa2, fb2}, 0);

    // Table-driven sweeps; each one after the first restarts from DONE
    for (int i = 0; i < 5; i++) sweep1(tbl[i]);

    // Reset in the middle of a failing sweep
    mode1 = 1;
    start1 = 1'b1;
    @(posedge clk); #1;          // E0
    start1 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end   // after E4
    chk("mid_err", err1, 1);
    chk("mid_fv", fv1, 1);
    rst = 1'b1;
    @(posedge clk); #1;          // E5
    rst = 1'b0;
    chk("midrst_busy", busy1, 0);
    chk("midrst_done", done1, 0);
    chk("midrst_pass", pass1, 0);
    chk("midrst_err", err1, 0);
    chk("midrst_fv", fv1, 0);
    chk("midrst_ops", {a1, b1, fa1, fb1}, 0);
    @(posedge clk); #1;
    chk("midrst_idle", busy1, 0);

    // rst and start on the same edge: reset wins
    rst = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start1 = 1'b0;
    chk("rst_over_start", busy1, 0);
    @(posedge clk); #1;
    chk("rst_over_start_idle", busy1, 0);

    // A later start runs a complete sweep
    sweep1(tbl[3]);

    // WIDTH=2, SETTLE=2 golden sweep: 16 vectors, 3 cycles each
    for (int k = 0; k < 16; k++) sb.push_back('{a: 8'(k >> 2), b: 8'(k & 3)});
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int e = 0; e < 48; e++) begin
      chk("w2_busy", busy2, 1);
      chk("w2_done_low", done2, 0);
      if (e % 3 == 0) pop_cmp("w2_op", 8'(a2), 8'(b2));
      if (e == 18) begin
        chk("w2_e18_a", a2, 1);
        chk("w2_e18_b", b2, 2);
      end
      @(posedge clk); #1;
    end
    chk("w2_done", done2, 1);
    chk("w2_busy_end", busy2, 0);
    chk("w2_pass", pass2, 1);
    chk("w2_err", err2, 0);
    chk("w2_fv", fv2, 0);
    chk("w2_sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
